// File: rtl/decoder.sv
// 8b/10b receive decoder: one 10-bit code group in, byte + K flag out with code/disparity error flags.
// Latency: 1 cycle; outputs and running disparity update only on cycles with RxWordValid set.
// Backpressure: none; every valid word is consumed in the cycle it is presented.
module decoder #(
    parameter logic       INIT_RD  = 1'b0,
    parameter logic [7:0] ERR_DATA = 8'h00
) (
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic [9:0] RxParallel_10,
    input  logic       RxWordValid,
    output logic [7:0] RxParallel_8,
    output logic       RxDataK,
    output logic       RxValid,
    output logic       CodeErr,
    output logic       DispErr,
    output logic       CommaDet,
    output logic       RunDisp
);

    logic [5:0] sb6;
    logic [3:0] sb4, k4;
    logic [2:0] ones6, ones4;
    logic [4:0] x5;
    logic [2:0] y3;
    logic       ok6, ok4, is_k28, is_kx7;
    logic       x_a7n, x_a7p, x_k7;
    logic       rd_mid, rd_new, code_err, disp_err;

    assign sb6    = RxParallel_10[9:4];
    assign sb4    = RxParallel_10[3:0];
    assign ones6  = 3'($countones(sb6));
    assign ones4  = 3'($countones(sb4));
    assign is_k28 = (sb6 == 6'b001111) || (sb6 == 6'b110000);
    // K28 fghj is carried in the RD- sense after 001111; fold the RD+ form onto it.
    assign k4     = (sb6 == 6'b110000) ? ~sb4 : sb4;

    assign x_a7n = (x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20);
    assign x_a7p = (x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14);
    assign x_k7  = (x5 == 5'd23) || (x5 == 5'd27) || (x5 == 5'd29) || (x5 == 5'd30);

    always_comb begin
        x5  = 5'd0;
        ok6 = 1'b1;
        case (sb6)
            6'b100111, 6'b011000: x5 = 5'd0;
            6'b011101, 6'b100010: x5 = 5'd1;
            6'b101101, 6'b010010: x5 = 5'd2;
            6'b110001:            x5 = 5'd3;
            6'b110101, 6'b001010: x5 = 5'd4;
            6'b101001:            x5 = 5'd5;
            6'b011001:            x5 = 5'd6;
            6'b111000, 6'b000111: x5 = 5'd7;
            6'b111001, 6'b000110: x5 = 5'd8;
            6'b100101:            x5 = 5'd9;
            6'b010101:            x5 = 5'd10;
            6'b110100:            x5 = 5'd11;
            6'b001101:            x5 = 5'd12;
            6'b101100:            x5 = 5'd13;
            6'b011100:            x5 = 5'd14;
            6'b010111, 6'b101000: x5 = 5'd15;
            6'b011011, 6'b100100: x5 = 5'd16;
            6'b100011:            x5 = 5'd17;
            6'b010011:            x5 = 5'd18;
            6'b110010:            x5 = 5'd19;
            6'b001011:            x5 = 5'd20;
            6'b101010:            x5 = 5'd21;
            6'b011010:            x5 = 5'd22;
            6'b111010, 6'b000101: x5 = 5'd23;
            6'b110011, 6'b001100: x5 = 5'd24;
            6'b100110:            x5 = 5'd25;
            6'b010110:            x5 = 5'd26;
            6'b110110, 6'b001001: x5 = 5'd27;
            6'b001110, 6'b001111, 6'b110000: x5 = 5'd28;
            6'b101110, 6'b010001: x5 = 5'd29;
            6'b011110, 6'b100001: x5 = 5'd30;
            6'b101011, 6'b010100: x5 = 5'd31;
            default:              ok6 = 1'b0;
        endcase
    end

    always_comb begin
        y3     = 3'd0;
        ok4    = 1'b1;
        is_kx7 = 1'b0;
        if (is_k28) begin
            case (k4)
                4'b0100: y3 = 3'd0;
                4'b1001: y3 = 3'd1;
                4'b0101: y3 = 3'd2;
                4'b0011: y3 = 3'd3;
                4'b0010: y3 = 3'd4;
                4'b1010: y3 = 3'd5;
                4'b0110: y3 = 3'd6;
                4'b1000: y3 = 3'd7;
                default: ok4 = 1'b0;
            endcase
        end else begin
            case (sb4)
                4'b1011, 4'b0100: y3 = 3'd0;
                4'b1001:          y3 = 3'd1;
                4'b0101:          y3 = 3'd2;
                4'b1100, 4'b0011: y3 = 3'd3;
                4'b1101, 4'b0010: y3 = 3'd4;
                4'b1010:          y3 = 3'd5;
                4'b0110:          y3 = 3'd6;
                4'b1110, 4'b0001, 4'b0111, 4'b1000: y3 = 3'd7;
                default:          ok4 = 1'b0;
            endcase
            // Alternate .7 is reserved for the few x values that would otherwise run-length violate.
            if (sb4 == 4'b0111 || sb4 == 4'b1000) begin
                is_kx7 = x_k7;
                if (!x_k7 && !((sb4 == 4'b0111) ? x_a7n : x_a7p))
                    ok4 = 1'b0;
            end
            if ((sb4 == 4'b1110 && x_a7n) || (sb4 == 4'b0001 && x_a7p))
                ok4 = 1'b0;
        end
    end

    always_comb begin
        rd_mid = RunDisp;
        if (ones6 > 3'd3)
            rd_mid = 1'b1;
        else if (ones6 < 3'd3)
            rd_mid = 1'b0;
        rd_new = rd_mid;
        if (ones4 > 3'd2)
            rd_new = 1'b1;
        else if (ones4 < 3'd2)
            rd_new = 1'b0;
        disp_err = (ones6 == 3'd4 && RunDisp) || (ones6 == 3'd2 && !RunDisp)
                || (sb6 == 6'b111000 && RunDisp) || (sb6 == 6'b000111 && !RunDisp)
                || (ones4 == 3'd3 && rd_mid) || (ones4 == 3'd1 && !rd_mid)
                || (sb4 == 4'b1100 && rd_mid) || (sb4 == 4'b0011 && !rd_mid);
        code_err = !ok6 || !ok4;
    end

    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            RxParallel_8 <= 8'h00;
            RxDataK      <= 1'b0;
            RxValid      <= 1'b0;
            CodeErr      <= 1'b0;
            DispErr      <= 1'b0;
            CommaDet     <= 1'b0;
            RunDisp      <= INIT_RD;
        end else begin
            RxValid <= RxWordValid;
            if (RxWordValid) begin
                RxParallel_8 <= code_err ? ERR_DATA : {y3, x5};
                RxDataK      <= !code_err && (is_k28 || is_kx7);
                CommaDet     <= !code_err && is_k28 && (y3 == 3'd1 || y3 == 3'd5 || y3 == 3'd7);
                CodeErr      <= code_err;
                DispErr      <= disp_err;
                RunDisp      <= rd_new;
            end
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Bench for the 8b/10b decoder: directed vectors, valid gaps, mid-stream reset,
// encoder loopback and random code groups checked against a table-driven reference.
module tb_decoder;

    logic       BitCLK_10     = 1'b0;
    logic       Reset         = 1'b1;
    logic [9:0] RxParallel_10 = '0;
    logic       RxWordValid   = 1'b0;
    logic [7:0] RxParallel_8;
    logic       RxDataK, RxValid, CodeErr, DispErr, CommaDet, RunDisp;

    int tests = 0;
    int fails = 0;

    // RD- forms of the 5b/6b and 3b/4b codes, K28 fghj in the RD- sense, and the K set.
    localparam logic [5:0] T6 [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] T4 [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] K4 [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] KL [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                          8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // Observation word layout: {RxValid, byte, K, CodeErr, DispErr, CommaDet, RunDisp}.
    localparam logic [9:0]  VW [0:6] = '{10'b1001110100, 10'b0011111010, 10'b1100000101, 10'b1100000101,
                                         10'b1111110000, 10'b1000110111, 10'b1000111110};
    localparam logic [13:0] VE [0:6] = '{{1'b1, 8'h00, 5'b00000}, {1'b1, 8'hBC, 5'b10011},
                                         {1'b1, 8'hBC, 5'b10010}, {1'b1, 8'hBC, 5'b10110},
                                         {1'b1, 8'h00, 5'b01000}, {1'b1, 8'hF1, 5'b00001},
                                         {1'b1, 8'h00, 5'b01101}};
    localparam logic [13:0] VM [0:6] = '{14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF,
                                         {1'b1, 8'hFF, 5'b11011}, 14'h3FFF, 14'h3FFF};

    decoder dut (
        .BitCLK_10     (BitCLK_10),
        .Reset         (Reset),
        .RxParallel_10 (RxParallel_10),
        .RxWordValid   (RxWordValid),
        .RxParallel_8  (RxParallel_8),
        .RxDataK       (RxDataK),
        .RxValid       (RxValid),
        .CodeErr       (CodeErr),
        .DispErr       (DispErr),
        .CommaDet      (CommaDet),
        .RunDisp       (RunDisp)
    );

    always #5 BitCLK_10 = ~BitCLK_10;

    function automatic logic [13:0] obs();
        return {RxValid, RxParallel_8, RxDataK, CodeErr, DispErr, CommaDet, RunDisp};
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rm;
        x  = b[4:0];
        y  = b[7:5];
        s6 = (k && x == 5'd28) ? 6'b001111 : T6[x];
        if (rd && ($countones(s6) != 3 || x == 5'd7))
            s6 = ~s6;
        rm = ($countones(s6) == 3) ? rd : ~rd;
        if (k && x == 5'd28)
            s4 = rd ? ~K4[y] : K4[y];
        else if (k)
            s4 = rm ? 4'b1000 : 4'b0111;
        else if (y == 3'd7 && ((!rm && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                               (rm && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            s4 = rm ? 4'b1000 : 4'b0111;
        else begin
            s4 = T4[y];
            if (rm && ($countones(s4) != 2 || y == 3'd3))
                s4 = ~s4;
        end
        return {s6, s4};
    endfunction

    function automatic logic rd_next(input logic [9:0] w, input logic rd);
        int   n6, n4;
        logic r;
        n6 = $countones(w[9:4]);
        n4 = $countones(w[3:0]);
        r  = rd;
        if (n6 > 3) r = 1'b1; else if (n6 < 3) r = 1'b0;
        if (n4 > 2) r = 1'b1; else if (n4 < 2) r = 1'b0;
        return r;
    endfunction

    function automatic logic disp_model(input logic [9:0] w, input logic rd);
        int   n6, n4;
        logic rm;
        n6 = $countones(w[9:4]);
        n4 = $countones(w[3:0]);
        rm = (n6 > 3) ? 1'b1 : ((n6 < 3) ? 1'b0 : rd);
        return (n6 == 4 && rd) || (n6 == 2 && !rd) || (w[9:4] == 6'b111000 && rd) || (w[9:4] == 6'b000111 && !rd)
            || (n4 == 3 && rm) || (n4 == 1 && !rm) || (w[3:0] == 4'b1100 && rm) || (w[3:0] == 4'b0011 && !rm);
    endfunction

    function automatic logic find(input logic [9:0] w, input logic rd, output logic [7:0] b, output logic k);
        logic hit;
        hit = 1'b0;
        b   = 8'h00;
        k   = 1'b0;
        for (int i = 0; i < 256; i++)
            if (enc(8'(i), 1'b0, rd) == w) begin hit = 1'b1; b = 8'(i); end
        for (int i = 0; i < 12; i++)
            if (enc(KL[i], 1'b1, rd) == w) begin hit = 1'b1; b = KL[i]; k = 1'b1; end
        return hit;
    endfunction

    function automatic logic is_comma(input logic [7:0] b, input logic k);
        return k && (b == 8'h3C || b == 8'hBC || b == 8'hFC);
    endfunction

    task automatic send(input logic [9:0] w, input logic v);
        @(negedge BitCLK_10);
        RxParallel_10 = w;
        RxWordValid   = v;
        @(posedge BitCLK_10);
        #1;
    endtask

    task automatic do_reset();
        @(negedge BitCLK_10);
        Reset       = 1'b0;
        RxWordValid = 1'b0;
        @(posedge BitCLK_10);
        @(negedge BitCLK_10);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        Reset         = 1'b0;
        RxWordValid   = 1'b1;
        RxParallel_10 = 10'b0011111010;
        repeat (2) @(posedge BitCLK_10);
        #1;
        tests++;
        if (obs() !== 14'h0) begin
            fails++;
            $display("FAIL reset_state: got %h want %h", obs(), 14'h0);
        end
        @(negedge BitCLK_10);
        Reset       = 1'b1;
        RxWordValid = 1'b0;
    endtask

    task automatic test_vectors();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(VW[i], 1'b1);
            tests++;
            if ((obs() & VM[i]) !== (VE[i] & VM[i])) begin
                fails++;
                $display("FAIL vector_%0d (%b): got %h want %h mask %h", i, VW[i], obs(), VE[i], VM[i]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [13:0] e [0:3];
        logic        v [0:3];
        e = '{{1'b1, 8'hBC, 5'b10011}, {1'b0, 8'hBC, 5'b10011}, {1'b0, 8'hBC, 5'b10011}, {1'b1, 8'hBC, 5'b10010}};
        v = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        tests++;
        if (RxValid !== 1'b0) begin
            fails++;
            $display("FAIL gap_pre_valid: got %b want 0", RxValid);
        end
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 10'b0011111010 : ((i == 3) ? 10'b1100000101 : 10'b1111110000), v[i]);
            tests++;
            if (obs() !== e[i]) begin
                fails++;
                $display("FAIL gap_step_%0d: got %h want %h", i, obs(), e[i]);
            end
        end
        send(10'b0011111010, 1'b1);
        @(negedge BitCLK_10);
        RxParallel_10 = 10'b1001110100;
        RxWordValid   = 1'b1;
        Reset         = 1'b0;
        #1;
        tests++;
        if (obs() !== 14'h0) begin
            fails++;
            $display("FAIL midburst_reset_immediate: got %h want %h", obs(), 14'h0);
        end
        @(posedge BitCLK_10);
        #1;
        tests++;
        if (obs() !== 14'h0) begin
            fails++;
            $display("FAIL midburst_reset_held: got %h want %h", obs(), 14'h0);
        end
        @(negedge BitCLK_10);
        Reset       = 1'b1;
        RxWordValid = 1'b0;
        send(10'b1100000101, 1'b1);
        tests++;
        if (obs() !== {1'b1, 8'hBC, 5'b10110}) begin
            fails++;
            $display("FAIL post_reset_rd: got %h want %h", obs(), {1'b1, 8'hBC, 5'b10110});
        end
    endtask

    task automatic test_loopback();
        logic        rd;
        logic [7:0]  b;
        logic        k;
        logic [9:0]  w;
        logic [13:0] e, last;
        do_reset();
        rd   = 1'b0;
        last = 14'h0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(9) == 0) begin
                send(10'($urandom), 1'b0);
                e = {1'b0, last[12:0]};
            end else begin
                k = ($urandom_range(7) == 0);
                b = k ? KL[$urandom_range(11)] : 8'($urandom);
                w = enc(b, k, rd);
                rd = rd_next(w, rd);
                send(w, 1'b1);
                e = {1'b1, b, k, 1'b0, 1'b0, is_comma(b, k), rd};
                last = e;
            end
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL loopback_%0d: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_random_words();
        logic        rd, hit, k, rd_after;
        logic [7:0]  b;
        logic [9:0]  w;
        logic [13:0] e, m;
        int          n6, n4;
        do_reset();
        rd = 1'b0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0:       w = enc(8'($urandom), 1'b0, rd);
                1:       w = enc(KL[$urandom_range(11)], 1'b1, ~rd);
                default: w = 10'($urandom);
            endcase
            hit      = find(w, rd, b, k);
            rd_after = rd_next(w, rd);
            n6 = $countones(w[9:4]);
            n4 = $countones(w[3:0]);
            e = {1'b1, 8'h00, 2'b00, disp_model(w, rd), 1'b0, rd_after};
            m = {1'b1, 8'h00, 5'b00101};
            if (hit) begin
                e = {1'b1, b, k, 1'b0, 1'b0, is_comma(b, k), rd_after};
                m = 14'h3FFF;
            end else if (n6 < 2 || n6 > 4 || n4 == 0 || n4 == 4) begin
                e = {1'b1, 8'h00, 2'b01, disp_model(w, rd), 1'b0, rd_after};
                m = 14'h3FFF;
            end
            send(w, 1'b1);
            rd = rd_after;
            tests++;
            if ((obs() & m) !== (e & m)) begin
                fails++;
                $display("FAIL random_word_%0d (%b): got %h want %h mask %h", i, w, obs(), e, m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_valid_gaps();
        test_loopback();
        test_random_words();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
